// File: rtl/mem_cycle_arb.sv
// Two-requester memory cycle arbiter.
// A granted cycle runs through a read phase, a one-cycle read strobe, a
// write/restore phase and a one-cycle completion pulse before returning to
// idle. Ties between the processor (0) and the I/O channel (1) are broken
// round-robin. Every output is decoded from registered state only, so there
// is no combinational path from req or en to any output.
module mem_cycle_arb #(
    parameter int T_RD = 4,
    parameter int T_WR = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] ack,
    output logic [1:0] rs,
    output logic [1:0] done,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       sel,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        STB  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    // Phase counters are loaded with length-1 and count down to zero.
    localparam logic [7:0] RD_LOAD = 8'(T_RD - 1);
    localparam logic [7:0] WR_LOAD = 8'(T_WR - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic       last_q, last_d;
    logic       winner;
    logic       ack_phase;

    // Round-robin pick: a lone request wins, a tie goes to whoever was not served last.
    always_comb begin
        winner = req[1];
        if (req == 2'b11) begin
            winner = ~last_q;
        end
    end

    // Next-state logic; requests are only looked at while idle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (en && (req != 2'b00)) begin
                    state_d = RD;
                    cnt_d   = RD_LOAD;
                    sel_d   = winner;
                end
            end
            RD: begin
                if (cnt_q == 8'd0) begin
                    state_d = STB;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            STB: begin
                state_d = WR;
                cnt_d   = WR_LOAD;
            end
            WR: begin
                if (cnt_q == 8'd0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = sel_q;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // State registers; reset abandons any cycle in flight without a done pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
        end
    end

    // The counter still holds its load value only in the first read cycle.
    assign ack_phase = (state_q == RD) && (cnt_q == RD_LOAD);

    // Steer the pulse outputs to the current owner only.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_steer
            assign ack[gi]  = ack_phase && (sel_q == 1'(gi));
            assign rs[gi]   = (state_q == STB) && (sel_q == 1'(gi));
            assign done[gi] = (state_q == DONE) && (sel_q == 1'(gi));
        end
    endgenerate

    assign mem_rd = (state_q == RD);
    assign mem_wr = (state_q == WR);
    assign sel    = sel_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_mem_cycle_arb.sv
// Bench for mem_cycle_arb: a timeline model (cycles elapsed since the grant)
// checked every cycle, plus directed scenarios with literal expectations.
module tb_mem_cycle_arb;

    localparam int TR = 4;
    localparam int TW = 4;

    logic       clk = 1'b0;
    logic       reset, en;
    logic [1:0] req;
    logic [1:0] ack, rs, done;
    logic       mem_rd, mem_wr, sel, busy;

    logic       reset2, en2;
    logic [1:0] req2;
    logic [1:0] ack2, rs2, done2;
    logic       mem_rd2, mem_wr2, sel2, busy2;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #10 clk = ~clk;

    mem_cycle_arb #(.T_RD(TR), .T_WR(TW)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req),
        .ack(ack), .rs(rs), .done(done),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .sel(sel), .busy(busy)
    );

    mem_cycle_arb #(.T_RD(1), .T_WR(255)) dut2 (
        .clk(clk), .reset(reset2), .en(en2), .req(req2),
        .ack(ack2), .rs(rs2), .done(done2),
        .mem_rd(mem_rd2), .mem_wr(mem_wr2), .sel(sel2), .busy(busy2)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: k = cycles since the grant edge (0 = idle).
    int k        = 0;
    bit own      = 1'b0;
    bit last_own = 1'b1;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k        <= 0;
            own      <= 1'b0;
            last_own <= 1'b1;
        end else if (k == 0) begin
            if (en && req != 2'b00) begin
                own <= (req == 2'b11) ? !last_own : req[1];
                k   <= 1;
            end
        end else if (k == TR + TW + 2) begin
            last_own <= own;
            k        <= 0;
        end else begin
            k <= k + 1;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            chk("m_ack", ack, (k == 1) ? (own ? 2 : 1) : 0);
            chk("m_mem_rd", mem_rd, (k >= 1 && k <= TR) ? 1 : 0);
            chk("m_rs", rs, (k == TR + 1) ? (own ? 2 : 1) : 0);
            chk("m_mem_wr", mem_wr, (k >= TR + 2 && k <= TR + TW + 1) ? 1 : 0);
            chk("m_done", done, (k == TR + TW + 2) ? (own ? 2 : 1) : 0);
            chk("m_busy", busy, (k != 0) ? 1 : 0);
            if (k != 0) chk("m_sel", sel, own);
            if (ack != 2'b00) $display("grant ack=%b sel=%0d cycle=%0d", ack, sel, cyc);
        end
    end

    task automatic wait_ack(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ack_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    initial begin
        bit         ok;
        int         prev;
        logic [1:0] tog [8];
        int         n_rd, n_wr, a_c, d_c, ovl, a_val;

        tog = '{2'b11, 2'b01, 2'b00, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};
        reset = 1'b1; en = 1'b0; req = 2'b00;
        reset2 = 1'b1; en2 = 1'b0; req2 = 2'b00;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_rs", rs, 0);
        chk("rst_done", done, 0);
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_sel", sel, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk); #2 reset = 1'b0;
        $display("reset state checked");

        // Single processor request with default timing, cycle by cycle
        @(negedge clk); req = 2'b01; en = 1'b1;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            chk("t1_ack", ack, (i == 1) ? 1 : 0);
            chk("t1_mem_rd", mem_rd, (i >= 1 && i <= 4) ? 1 : 0);
            chk("t1_rs", rs, (i == 5) ? 1 : 0);
            chk("t1_mem_wr", mem_wr, (i >= 6 && i <= 9) ? 1 : 0);
            chk("t1_done", done, (i == 10) ? 1 : 0);
            chk("t1_busy", busy, (i <= 10) ? 1 : 0);
            if (i == 1) req = 2'b00;
        end
        $display("single request timeline done");

        // Continuous tie after reset alternates owners, 11 clocks apart
        @(posedge clk); #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk); req = 2'b11;
        prev = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ack(ok);
            if (ok) begin
                chk("t2_owner", ack, (g % 2 == 0) ? 1 : 2);
                chk("t2_sel", sel, g % 2);
                if (g > 0) chk("t2_spacing", cyc - prev, 11);
                prev = cyc;
            end
        end
        req = 2'b00;
        wait_idle();
        $display("round-robin sequence done");

        // Disabled: no grant; enabling grants on the next edge
        @(negedge clk); en = 1'b0; req = 2'b10;
        repeat (3) begin
            @(negedge clk);
            chk("t3_noack", ack, 0);
            chk("t3_idle", busy, 0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("t3_ack", ack, 2);
        chk("t3_sel", sel, 1);
        // req toggles and en drop mid-cycle must not disturb the cycle
        for (int i = 0; i < 8; i++) begin
            req = tog[i];
            if (i == 1) en = 1'b0;
            @(negedge clk);
            chk("t3_sel_hold", sel, 1);
        end
        req = 2'b01;
        wait_idle();
        repeat (4) begin
            @(negedge clk);
            chk("t3_hold_idle", busy, 0);
        end
        en = 1'b1;
        @(negedge clk);
        chk("t3_reen_ack", ack, 1);
        req = 2'b00;
        $display("enable gating and input isolation done");

        // Reset during the second write cycle
        repeat (6) @(negedge clk);
        chk("t4_in_wr", mem_wr, 1);
        #1 reset = 1'b1;
        #1;
        chk("t4_wr_drop", mem_wr, 0);
        chk("t4_busy_drop", busy, 0);
        chk("t4_done_rst", done, 0);
        @(posedge clk); #2 reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("t4_no_done", done, 0);
        end
        req = 2'b10;
        @(negedge clk);
        chk("t4_ack", ack, 2);
        chk("t4_sel", sel, 1);
        req = 2'b00;
        wait_idle();
        $display("mid-cycle reset done");

        // Extreme phase lengths on the second instance
        @(posedge clk); #2 reset2 = 1'b0;
        @(negedge clk); req2 = 2'b01; en2 = 1'b1;
        n_rd = 0; n_wr = 0; a_c = -1; d_c = -1; ovl = 0; a_val = 0;
        for (int i = 0; i < 301; i++) begin
            @(negedge clk);
            if (i == 0) req2 = 2'b00;
            if (ack2 != 2'b00) begin
                a_c   = cyc;
                a_val = int'(ack2);
            end
            if (done2 != 2'b00) d_c = cyc;
            n_rd += int'(mem_rd2);
            n_wr += int'(mem_wr2);
            if (mem_rd2 && mem_wr2) ovl++;
            if (a_c >= 0 && d_c >= 0 && !busy2) break;
        end
        chk("t5_ack", a_val, 1);
        chk("t5_rd_len", n_rd, 1);
        chk("t5_wr_len", n_wr, 255);
        chk("t5_span", (a_c >= 0 && d_c >= 0) ? d_c - a_c + 1 : -1, 258);
        chk("t5_overlap", ovl, 0);
        $display("T_RD=1 T_WR=255 cycle done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_cycle_arb.md
MEM_CYCLE_ARB -- requirements
Module: mem_cycle_arb

Interface
REQ-001 SHALL have parameter T_RD, default 4, meaning read-phase length in clk cycles (legal range 1..255).
REQ-002 SHALL have parameter T_WR, default 4, meaning write/restore-phase length in clk cycles (legal range 1..255).
REQ-003 SHALL have port clk, input, 1 bit: system clock, 50 MHz; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: when 1, new grants are allowed.
REQ-006 SHALL have port req, input, 2 bits: level request per requester (bit 0 = processor, bit 1 = I/O channel).
REQ-007 SHALL have port ack, output, 2 bits: one-clk grant pulse to the granted requester.
REQ-008 SHALL have port rs, output, 2 bits: one-clk read-strobe pulse; data is valid on the memory bus for the granted requester.
REQ-009 SHALL have port done, output, 2 bits: one-clk end-of-cycle pulse to the granted requester.
REQ-010 SHALL have port mem_rd, output, 1 bit: read-phase level to the memory.
REQ-011 SHALL have port mem_wr, output, 1 bit: write/restore-phase level to the memory.
REQ-012 SHALL have port sel, output, 1 bit: index of the current owner, held stable from ack through done.
REQ-013 SHALL have port busy, output, 1 bit: 1 in every state except IDLE.

Function
REQ-014 SHALL implement the states IDLE, RD, STB, WR, DONE; all outputs SHALL be registered or decoded from state registers only, with no combinational path from req or en.
REQ-015 IDLE SHALL move to RD when en=1 and req!=0; otherwise it SHALL remain in IDLE.
REQ-016 Requests SHALL be sampled only in IDLE; req changes in any other state SHALL be ignored.
REQ-017 Arbitration: a single request SHALL win; when both requests are active, the requester not granted last SHALL win (round-robin); the winner SHALL be latched into sel on the IDLE->RD edge.
REQ-018 ack[sel] SHALL be 1 during the first RD cycle only.
REQ-019 RD: mem_rd=1 for exactly T_RD consecutive cycles, then RD->STB.
REQ-020 STB: rs[sel]=1 for 1 cycle; mem_rd=0 and mem_wr=0; then STB->WR.
REQ-021 WR: mem_wr=1 for exactly T_WR consecutive cycles, then WR->DONE.
REQ-022 DONE: done[sel]=1 for 1 cycle; last-grant register <= sel; then DONE->IDLE.
REQ-023 The minimum spacing between back-to-back ack pulses SHALL be T_RD+T_WR+3 clks (IDLE always lasts at least 1 cycle).
REQ-024 The phase counter SHALL be 8 bits, loaded with T-1 on phase entry and counting down to 0; it SHALL never wrap.
REQ-025 mem_rd and mem_wr SHALL never be 1 simultaneously; ack, rs and done SHALL each be one-hot or zero.
REQ-026 en falling mid-cycle SHALL NOT abort the cycle; the cycle completes and the block then holds in IDLE.
REQ-027 A requester SHALL drop req after ack; if req is still high when the block returns to IDLE, it SHALL be treated as a new request, subject to round-robin.

Reset
REQ-028 reset=1 SHALL force, asynchronously: state=IDLE; counter=0; ack, rs, done = 0; mem_rd, mem_wr, busy = 0; sel=0; last-grant=1 (so requester 0 wins the first tie).
REQ-029 reset asserted mid-cycle SHALL drop mem_rd/mem_wr immediately, and no done pulse SHALL follow.
REQ-030 After reset is released, the first grant SHALL be possible on the first clk edge with en=1 and req!=0.

Verification
REQ-031 Defaults, req=01 for 1 clk, en=1 -> ack=01 at cycle 1; mem_rd high at cycles 1-4; rs=01 at cycle 5; mem_wr high at cycles 6-9; done=01 at cycle 10; busy low at cycle 11.
REQ-032 After reset, req=11 held continuously -> grants alternate 0,1,0,1; ack pulses 11 clks apart; sel matches each ack.
REQ-033 en=0, req=10 -> no ack and busy=0; raise en -> ack=10 on the next edge.
REQ-034 reset pulsed at the 2nd WR cycle -> mem_wr=0 at once, no done; the next req=10 is granted normally with sel=1.
REQ-035 T_RD=1, T_WR=255 -> mem_rd 1 clk, mem_wr exactly 255 clks, ack-to-done 258 clks.
REQ-036 req toggled during RD/WR -> no effect on sel, state or outputs until IDLE.
